// File: rtl/rls_pkg.sv
// Shared definitions for the RLS solver and its output paths: default
// vector geometry, the streamer FSM state type and a clog2 helper.
package rls_pkg;

    localparam int RLS_SIZE  = 8;
    localparam int RLS_WIDTH = 32;
    localparam int RLS_FRAC  = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rls_fix_narrow.sv
// Combinational fixed-point narrowing: arithmetic right shift to drop
// surplus fractional bits (rounds toward minus infinity), then clamp to
// the signed output range and flag any clamping.
module rls_fix_narrow #(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 8
) (
    input  logic [WIDTH-1:0]     din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    localparam int SHIFT = FRAC - OUT_FRAC;
    localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WIDTH-1:0] MIN_V = ~MAX_V;

    logic signed [WIDTH-1:0] shifted;

    // Shift into the output scaling, then saturate at either rail.
    always_comb begin
        shifted = $signed(din) >>> SHIFT;
        dout    = shifted[OUT_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > MAX_V) begin
            dout = MAX_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < MIN_V) begin
            dout = MIN_V[OUT_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/rls_result_streamer.sv
// Output stage of the RLS solver: captures a solution vector per block,
// streams it out one narrowed word per valid/ready handshake, and keeps
// one pending block so the solver can publish ahead. Loads arriving with
// both slots busy are dropped and flagged with a sticky overrun.
module rls_result_streamer
    import rls_pkg::*;
#(
    parameter int SIZE      = RLS_SIZE,
    parameter int WIDTH     = RLS_WIDTH,
    parameter int FRAC      = RLS_FRAC,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*SIZE-1:0]    x,
    input  logic                     x_load,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic [clog2(SIZE)-1:0]   out_index,
    output logic                     out_sat,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              block_id,
    output logic                     overrun,
    output logic                     busy
);

    localparam int IDX_W = clog2(SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    stream_state_e state_q, state_d;

    logic [WIDTH-1:0] x_words  [SIZE];
    logic [WIDTH-1:0] active_q [SIZE];
    logic [WIDTH-1:0] active_d [SIZE];
    logic [WIDTH-1:0] pend_q   [SIZE];
    logic [WIDTH-1:0] pend_d   [SIZE];

    logic                 pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [15:0]          load_cnt_q, load_cnt_d;
    logic [15:0]          block_id_q, block_id_d;
    logic [15:0]          pend_id_q, pend_id_d;
    logic                 overrun_q, overrun_d;
    logic [OUT_WIDTH-1:0] out_data_q, conv_data;
    logic                 out_sat_q, conv_sat;
    logic                 out_last_q, out_valid_q, busy_q;
    logic [WIDTH-1:0]     sel_word;
    logic                 handshake, last_beat;

    assign handshake = out_valid_q & out_ready;
    assign last_beat = handshake && (index_q == LAST_IDX);

    // Split the flat input bus into per-coefficient words.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            x_words[i] = x[WIDTH*i +: WIDTH];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: leave STREAM only when the last beat retires with nothing queued behind it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (x_load) state_d = ST_STREAM;
            ST_STREAM: if (last_beat && !pend_valid_q && !x_load) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Slot management, block numbering and overrun detection for the next cycle.
    always_comb begin
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        index_d      = index_q;
        load_cnt_d   = load_cnt_q;
        block_id_d   = block_id_q;
        pend_id_d    = pend_id_q;
        overrun_d    = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (x_load) begin
                    active_d   = x_words;
                    index_d    = '0;
                    block_id_d = load_cnt_q;
                    load_cnt_d = load_cnt_q + 16'd1;
                end
            end
            ST_STREAM: begin
                if (last_beat) begin
                    index_d = '0;
                    if (pend_valid_q) begin
                        active_d     = pend_q;
                        block_id_d   = pend_id_q;
                        pend_valid_d = x_load;
                        if (x_load) begin
                            pend_d     = x_words;
                            pend_id_d  = load_cnt_q;
                            load_cnt_d = load_cnt_q + 16'd1;
                        end
                    end else if (x_load) begin
                        active_d   = x_words;
                        block_id_d = load_cnt_q;
                        load_cnt_d = load_cnt_q + 16'd1;
                    end
                end else begin
                    if (handshake) index_d = index_q + IDX_W'(1);
                    if (x_load) begin
                        if (!pend_valid_q) begin
                            pend_d       = x_words;
                            pend_valid_d = 1'b1;
                            pend_id_d    = load_cnt_q;
                            load_cnt_d   = load_cnt_q + 16'd1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // The word presented next cycle is narrowed here so the output can be registered.
    always_comb begin
        sel_word = active_d[index_d];
    end

    rls_fix_narrow #(
        .WIDTH     (WIDTH),
        .FRAC      (FRAC),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_FRAC  (OUT_FRAC)
    ) u_narrow (
        .din  (sel_word),
        .dout (conv_data),
        .sat  (conv_sat)
    );

    // Datapath and output registers; reset discards both slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SIZE; i++) begin
                active_q[i] <= '0;
                pend_q[i]   <= '0;
            end
            pend_valid_q <= 1'b0;
            index_q      <= '0;
            load_cnt_q   <= '0;
            block_id_q   <= '0;
            pend_id_q    <= '0;
            overrun_q    <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            index_q      <= index_d;
            load_cnt_q   <= load_cnt_d;
            block_id_q   <= block_id_d;
            pend_id_q    <= pend_id_d;
            overrun_q    <= overrun_d;
            out_data_q   <= conv_data;
            out_sat_q    <= conv_sat;
            out_last_q   <= (index_d == LAST_IDX);
            out_valid_q  <= (state_d == ST_STREAM);
            busy_q       <= (state_d == ST_STREAM) || pend_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_index = index_q;
    assign out_sat   = out_sat_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign block_id  = block_id_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rls_result_streamer.sv
// Bench for rls_result_streamer: a block-level queue model predicts every
// presented beat, checked each cycle, plus hand-computed literal pins.
module tb_rls_result_streamer;

    localparam int SIZE  = 8;
    localparam int WIDTH = 32;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        int          idx;
        logic [15:0] id;
        logic        last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [WIDTH*SIZE-1:0] x = '0;
    logic                  x_load = 1'b0;
    logic                  out_ready = 1'b0;
    logic [15:0]           out_data;
    logic [2:0]            out_index;
    logic                  out_sat;
    logic                  out_last;
    logic                  out_valid;
    logic [15:0]           block_id;
    logic                  overrun;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    beat_t       exp_q[$];
    beat_t       hs_log[$];
    int          blocks = 0;
    logic [15:0] load_cnt = 16'd0;
    logic        ovr_exp = 1'b0;

    rls_result_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .x_load    (x_load),
        .out_data  (out_data),
        .out_index (out_index),
        .out_sat   (out_sat),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .block_id  (block_id),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Q16.16 -> Q8.8 by floor division and clamping; bit 16 is the sat flag.
    function automatic logic [16:0] conv(input logic [31:0] w);
        longint v;
        longint q;
        v = longint'($signed(w));
        q = v / 256;
        if (v < 0 && (v % 256) != 0) q = q - 1;
        if (q > 32767)  return {1'b1, 16'h7FFF};
        if (q < -32768) return {1'b1, 16'h8000};
        return {1'b0, q[15:0]};
    endfunction

    // Block model: at most two blocks in flight (streaming + pending), counting the one retiring this edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            blocks   = 0;
            load_cnt = 16'd0;
            ovr_exp  = 1'b0;
        end else begin
            beat_t b;
            logic [16:0] c;
            if (exp_q.size() > 0 && out_ready) begin
                b = exp_q.pop_front();
                if (b.last) blocks--;
            end
            if (x_load) begin
                if (blocks < 2) begin
                    for (int i = 0; i < SIZE; i++) begin
                        c = conv(x[WIDTH*i +: WIDTH]);
                        exp_q.push_back('{data: c[15:0], sat: c[16], idx: i, id: load_cnt, last: (i == SIZE - 1)});
                    end
                    load_cnt = load_cnt + 16'd1;
                    blocks++;
                end else begin
                    ovr_exp = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, and a log of DUT handshakes for literal pins.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            checkOutput("busy", 32'(busy), 32'(blocks > 0));
            checkOutput("overrun", 32'(overrun), 32'(ovr_exp));
            if (exp_q.size() > 0) begin
                checkOutput("out_data", 32'(out_data), 32'(exp_q[0].data));
                checkOutput("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
                checkOutput("out_index", 32'(out_index), 32'(exp_q[0].idx));
                checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
                checkOutput("block_id", 32'(block_id), 32'(exp_q[0].id));
            end
            if (out_valid && out_ready)
                hs_log.push_back('{data: out_data, sat: out_sat, idx: int'(out_index), id: block_id, last: out_last});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One-cycle load strobe carrying vector v.
    task automatic applyStimulus(input logic [WIDTH*SIZE-1:0] v);
        x = v;
        x_load = 1'b1;
        @(posedge clk);
        #2;
        x_load = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        logic [WIDTH*SIZE-1:0] v_ramp, v_sat, v_rnd, v_a, v_b, v_c;

        for (int i = 0; i < SIZE; i++) begin
            v_ramp[WIDTH*i +: WIDTH] = 32'h0001_8000 * 32'(i + 1);
            v_rnd[WIDTH*i +: WIDTH]  = $urandom;
            v_a[WIDTH*i +: WIDTH]    = 32'h0000_0100 * 32'(i + 1);
            v_b[WIDTH*i +: WIDTH]    = 32'hFFF0_0000 + 32'h0003_1234 * 32'(i);
            v_c[WIDTH*i +: WIDTH]    = 32'h0040_0000 - 32'h0011_0000 * 32'(i);
        end
        v_sat = '0;
        v_sat[31:0]  = 32'h0100_0000;
        v_sat[63:32] = 32'h8000_0000;
        v_sat[95:64] = 32'hFFFF_8000;

        // Reset values while reset is held low.
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_index", 32'(out_index), 32'd0);
        checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_block_id", 32'(block_id), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        wait_cycles(1);
        reset = 1'b1;

        // Single block at full rate.
        $display("[TB] single block");
        hs_log.delete();
        out_ready = 1'b1;
        applyStimulus(v_ramp);
        wait_cycles(12);
        checkOutput("t1_beats", 32'(hs_log.size()), 32'd8);
        checkOutput("t1_data0", 32'(hs_log[0].data), 32'h0180);
        checkOutput("t1_data7", 32'(hs_log[7].data), 32'h0C00);
        checkOutput("t1_idx7", 32'(hs_log[7].idx), 32'd7);
        checkOutput("t1_last7", 32'(hs_log[7].last), 32'd1);
        checkOutput("t1_idle", 32'(out_valid), 32'd0);

        // Saturation at both rails and a small negative value.
        $display("[TB] saturation");
        hs_log.delete();
        applyStimulus(v_sat);
        wait_cycles(12);
        checkOutput("t2_data0", 32'(hs_log[0].data), 32'h7FFF);
        checkOutput("t2_sat0", 32'(hs_log[0].sat), 32'd1);
        checkOutput("t2_data1", 32'(hs_log[1].data), 32'h8000);
        checkOutput("t2_sat1", 32'(hs_log[1].sat), 32'd1);
        checkOutput("t2_data2", 32'(hs_log[2].data), 32'hFF80);
        checkOutput("t2_sat2", 32'(hs_log[2].sat), 32'd0);
        checkOutput("t2_id", 32'(hs_log[0].id), 32'd1);

        // Random backpressure.
        $display("[TB] backpressure");
        hs_log.delete();
        out_ready = 1'b0;
        applyStimulus(v_rnd);
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            wait_cycles(1);
        end
        out_ready = 1'b1;
        wait_cycles(12);
        checkOutput("t3_beats", 32'(hs_log.size()), 32'd8);
        for (int k = 0; k < hs_log.size(); k++)
            checkOutput("t3_order", 32'(hs_log[k].idx), 32'(k));
        checkOutput("t3_id", 32'(hs_log[0].id), 32'd2);

        // Back-to-back: second load mid-stream, third on the last beat.
        $display("[TB] back-to-back");
        apply_reset();
        hs_log.delete();
        out_ready = 1'b1;
        applyStimulus(v_a);
        wait_cycles(3);
        applyStimulus(v_b);
        wait_cycles(3);
        applyStimulus(v_c);
        wait_cycles(26);
        checkOutput("t4_beats", 32'(hs_log.size()), 32'd24);
        checkOutput("t4_id0", 32'(hs_log[0].id), 32'd0);
        checkOutput("t4_id1", 32'(hs_log[8].id), 32'd1);
        checkOutput("t4_id2", 32'(hs_log[16].id), 32'd2);
        checkOutput("t4_overrun", 32'(overrun), 32'd0);

        // Overrun: third load while stalled with pending full is dropped.
        $display("[TB] overrun");
        apply_reset();
        hs_log.delete();
        out_ready = 1'b0;
        applyStimulus(v_a);
        wait_cycles(1);
        applyStimulus(v_b);
        applyStimulus(v_c);
        checkOutput("t5_overrun_set", 32'(overrun), 32'd1);
        checkOutput("t5_stall_idx", 32'(out_index), 32'd0);
        out_ready = 1'b1;
        wait_cycles(20);
        applyStimulus(v_ramp);
        wait_cycles(12);
        checkOutput("t5_beats", 32'(hs_log.size()), 32'd24);
        checkOutput("t5_id_pend", 32'(hs_log[8].id), 32'd1);
        checkOutput("t5_id_next", 32'(hs_log[16].id), 32'd2);
        checkOutput("t5_data_next", 32'(hs_log[16].data), 32'h0180);
        checkOutput("t5_overrun_sticky", 32'(overrun), 32'd1);

        // Reset at beat 4 with the pending slot full.
        $display("[TB] reset mid-stream");
        hs_log.delete();
        applyStimulus(v_a);
        applyStimulus(v_b);
        wait_cycles(3);
        checkOutput("t6_pre_idx", 32'(out_index), 32'd4);
        checkOutput("t6_pre_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_out_data", 32'(out_data), 32'd0);
        checkOutput("t6_out_index", 32'(out_index), 32'd0);
        checkOutput("t6_out_last", 32'(out_last), 32'd0);
        checkOutput("t6_block_id", 32'(block_id), 32'd0);
        checkOutput("t6_overrun", 32'(overrun), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        wait_cycles(1);
        reset = 1'b1;
        hs_log.delete();
        applyStimulus(v_ramp);
        wait_cycles(12);
        checkOutput("t6_beats", 32'(hs_log.size()), 32'd8);
        checkOutput("t6_id", 32'(hs_log[0].id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
